display_driver_scan_controller: RTL and testbench

DISPLAY_DRIVER_SCAN_CONTROLLER -- requirements
Module: display_driver_scan_controller

---
 rtl/display_driver_pkg.sv | 23 ++
 rtl/display_driver_oe_timer.sv | 70 +++++++
 rtl/display_driver_scan_controller.sv | 150 +++++++++++++++
 tb/tb_display_driver_scan_controller.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/display_driver_pkg.sv
// Shared scan-state encoding, default geometry and timing constants
// for the display driver scan controller.
package display_driver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BLANK,
    ST_LATCH,
    ST_DISPLAY
  } scan_state_t;

  localparam int DEF_ROWS         = 16;
  localparam int DEF_BITWIDTH     = 8;
  localparam int DEF_BASE_TIME    = 32;
  localparam int DEF_BLANK_CYCLES = 2;

  // Counter width that holds the longest plane period (top plane) without overflow.
  function automatic int count_width(input int base_cycles, input int planes);
    return $clog2(base_cycles << (planes - 1)) + 1;
  endfunction

endpackage

// File: rtl/display_driver_oe_timer.sv
// DISPLAY-phase timer: plane-weighted period counter and registered oe.
// Optional brightness compare enabled by DISPLAY_DRIVER_DIMMING_EN.
module display_driver_oe_timer
  import display_driver_pkg::*;
#(
  parameter int bitwidth  = DEF_BITWIDTH,
  parameter int base_time = DEF_BASE_TIME
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_start,
  input  logic [$clog2(bitwidth)-1:0] i_plane,
`ifdef DISPLAY_DRIVER_DIMMING_EN
  input  logic [7:0]                  i_brightness,
`endif
  output logic                        o_oe,
  output logic                        o_done
);

  localparam int CW = count_width(base_time, bitwidth);

  logic [CW-1:0] r_count;
  logic          r_active;
  logic          r_oe;

  logic [CW-1:0] w_period;
  logic [CW-1:0] w_last;
  logic [CW-1:0] w_thresh;
  logic [CW-1:0] w_count_inc;

  assign w_period    = CW'(base_time) << i_plane;
  assign w_last      = w_period - CW'(1);
  assign w_count_inc = r_count + CW'(1);

`ifdef DISPLAY_DRIVER_DIMMING_EN
  // On-time is the period scaled by (brightness+1)/256; the period itself never shrinks.
  logic [8:0]    w_bright_plus;
  logic [CW+8:0] w_scaled;

  assign w_bright_plus = {1'b0, i_brightness} + 9'd1;
  assign w_scaled      = {9'd0, w_period} * {{CW{1'b0}}, w_bright_plus};
  assign w_thresh      = w_scaled[CW+7:8];
`else
  assign w_thresh = w_period;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active <= 1'b0;
      r_count  <= '0;
      r_oe     <= 1'b0;
    end else if (i_start) begin
      r_active <= 1'b1;
      r_count  <= '0;
      r_oe     <= (w_thresh != '0);
    end else if (r_active) begin
      if (r_count == w_last) begin
        r_active <= 1'b0;
        r_oe     <= 1'b0;
      end else begin
        r_count <= w_count_inc;
        r_oe    <= (w_count_inc < w_thresh);
      end
    end
  end

  assign o_oe   = r_oe;
  assign o_done = r_active && (r_count == w_last);

endmodule

// File: rtl/display_driver_scan_controller.sv
// Row/bit-plane scan sequencer for a multiplexed LED panel (BCM timing).
// Define DISPLAY_DRIVER_DIMMING_EN to add the brightness input.
module display_driver_scan_controller
  import display_driver_pkg::*;
#(
  parameter int rows         = DEF_ROWS,
  parameter int bitwidth     = DEF_BITWIDTH,
  parameter int base_time    = DEF_BASE_TIME,
  parameter int blank_cycles = DEF_BLANK_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  output logic                        load,
  input  logic                        complete,
  output logic                        latch,
  output logic                        oe,
  output logic [$clog2(rows)-1:0]     row_addr,
  output logic [$clog2(rows)-1:0]     fetch_row,
  output logic [$clog2(bitwidth)-1:0] fetch_plane,
  output logic                        frame_start
`ifdef DISPLAY_DRIVER_DIMMING_EN
  ,
  input  logic [7:0]                  brightness
`endif
);

  localparam int RW = $clog2(rows);
  localparam int PW = $clog2(bitwidth);
  localparam int BW = $clog2(blank_cycles) + 1;

  localparam logic [RW-1:0] LAST_ROW   = RW'(rows - 1);
  localparam logic [PW-1:0] LAST_PLANE = PW'(bitwidth - 1);
  localparam logic [BW-1:0] LAST_BLANK = BW'(blank_cycles - 1);

  scan_state_t   r_state;
  logic [RW-1:0] r_row;
  logic [PW-1:0] r_plane;
  logic [RW-1:0] r_row_addr;
  logic [BW-1:0] r_blank_cnt;
  logic          r_load;
  logic          r_latch;
  logic          r_frame_start;

  logic [RW-1:0] w_next_row;
  logic [PW-1:0] w_next_plane;
  logic          w_disp_start;
  logic          w_disp_done;
  logic          w_oe;

  // Plane advances first; the row steps only when the top plane has been shown.
  always_comb begin
    w_next_row   = r_row;
    w_next_plane = r_plane + PW'(1);
    if (r_plane == LAST_PLANE) begin
      w_next_plane = '0;
      w_next_row   = (r_row == LAST_ROW) ? '0 : r_row + RW'(1);
    end
  end

  assign w_disp_start = (r_state == ST_LATCH);

  display_driver_oe_timer #(
    .bitwidth  (bitwidth),
    .base_time (base_time)
  ) u_oe_timer (
    .clk          (clk),
    .rst          (rst),
    .i_start      (w_disp_start),
    .i_plane      (r_plane),
`ifdef DISPLAY_DRIVER_DIMMING_EN
    .i_brightness (brightness),
`endif
    .o_oe         (w_oe),
    .o_done       (w_disp_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_row         <= '0;
      r_plane       <= '0;
      r_row_addr    <= '0;
      r_blank_cnt   <= '0;
      r_load        <= 1'b0;
      r_latch       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (enable) begin
            r_state       <= ST_LOAD;
            r_row         <= '0;
            r_plane       <= '0;
            r_load        <= 1'b1;
            r_frame_start <= 1'b1;
          end
        end
        ST_LOAD: begin
          // The row select moves only here, where oe is guaranteed low.
          if (complete) begin
            r_load      <= 1'b0;
            r_row_addr  <= r_row;
            r_blank_cnt <= '0;
            r_state     <= ST_BLANK;
          end
        end
        ST_BLANK: begin
          if (r_blank_cnt == LAST_BLANK) begin
            r_latch <= 1'b1;
            r_state <= ST_LATCH;
          end else begin
            r_blank_cnt <= r_blank_cnt + BW'(1);
          end
        end
        ST_LATCH: begin
          r_latch <= 1'b0;
          r_state <= ST_DISPLAY;
        end
        ST_DISPLAY: begin
          if (w_disp_done) begin
            if (enable) begin
              r_row         <= w_next_row;
              r_plane       <= w_next_plane;
              r_load        <= 1'b1;
              r_frame_start <= (w_next_row == '0) && (w_next_plane == '0);
              r_state       <= ST_LOAD;
            end else begin
              r_row      <= '0;
              r_plane    <= '0;
              r_row_addr <= '0;
              r_state    <= ST_IDLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load        = r_load;
  assign latch       = r_latch;
  assign oe          = w_oe;
  assign row_addr    = r_row_addr;
  assign fetch_row   = r_row;
  assign fetch_plane = r_plane;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_driver_scan_controller.sv
// Scoreboard bench for the scan controller: 2 rows, 2 planes, base 4, blank 2.
module tb_display_driver_scan_controller;

  localparam int ROWS  = 2;
  localparam int BITW  = 2;
  localparam int BASE  = 4;
  localparam int BLANK = 2;

  typedef struct {
    int row;
    int plane;
    int fs;
    int oe_len;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic enable;
  logic complete;
  logic load;
  logic latch;
  logic oe;
  logic frame_start;
  logic [$clog2(ROWS)-1:0] row_addr;
  logic [$clog2(ROWS)-1:0] fetch_row;
  logic [$clog2(BITW)-1:0] fetch_plane;
`ifdef DISPLAY_DRIVER_DIMMING_EN
  logic [7:0] brightness = 8'd255;
`endif

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_row    = 0;
  int   m_plane  = 0;

  display_driver_scan_controller #(
    .rows         (ROWS),
    .bitwidth     (BITW),
    .base_time    (BASE),
    .blank_cycles (BLANK)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .load        (load),
    .complete    (complete),
    .latch       (latch),
    .oe          (oe),
    .row_addr    (row_addr),
    .fetch_row   (fetch_row),
    .fetch_plane (fetch_plane),
    .frame_start (frame_start)
`ifdef DISPLAY_DRIVER_DIMMING_EN
    ,
    .brightness  (brightness)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_next();
    m_plane++;
    if (m_plane == BITW) begin
      m_plane = 0;
      m_row   = (m_row + 1) % ROWS;
    end
  endtask

  // One LOAD/BLANK/LATCH/DISPLAY transaction; entered at a negedge sample.
  task automatic do_slot(input bit drop_en, input bit rst_mid, input bit spurious);
    int   n;
    int   k;
    int   s_row;
    int   s_plane;
    int   s_fs;
    int   got_ra;
    int   oe_seen;
    int   ra_bad;
    exp_t e;
    n = 0;
    while (!load && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!load) begin
      check("load_timeout", 0, 1);
      return;
    end
    s_row   = int'(fetch_row);
    s_plane = int'(fetch_plane);
    s_fs    = int'(frame_start);
    check("load_latch_excl", int'(latch), 0);
    if (drop_en) enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("fetch_stable", int'(fetch_row) * 16 + int'(fetch_plane), s_row * 16 + s_plane);
    complete = 1'b1;
    e.row    = m_row;
    e.plane  = m_plane;
    e.fs     = (m_row == 0 && m_plane == 0) ? 1 : 0;
    e.oe_len = BASE << m_plane;
    sb.push_back(e);
    @(negedge clk);
    complete = 1'b0;
    check("load_drop", int'(load), 0);
    got_ra  = int'(row_addr);
    oe_seen = 0;
    ra_bad  = 0;
    n = 0;
    while (!latch && n < 20) begin
      if (oe) oe_seen = 1;
      if (int'(row_addr) != got_ra) ra_bad = 1;
      n++;
      @(negedge clk);
    end
    check("blank_len", n, BLANK);
    check("oe_at_latch", int'(oe), 0);
    @(negedge clk);
    check("latch_width", int'(latch), 0);
    k = 0;
    while (oe && k < 100) begin
      if (int'(row_addr) != got_ra || latch) ra_bad = 1;
      if (spurious) complete = (k == 1);
      k++;
      if (rst_mid && k == 3) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_oe", int'(oe), 0);
        check("rst_row_addr", int'(row_addr), 0);
        check("rst_load", int'(load), 0);
        check("rst_slot", int'(fetch_row) * 16 + int'(fetch_plane), 0);
        e = sb.pop_front();
        $display("slot row=%0d plane=%0d interrupted by reset after %0d oe cycles", e.row, e.plane, k);
        m_row   = 0;
        m_plane = 0;
        return;
      end
      @(negedge clk);
    end
    complete = 1'b0;
    e = sb.pop_front();
    check("slot_row", s_row, e.row);
    check("slot_plane", s_plane, e.plane);
    check("frame_start", s_fs, e.fs);
    check("row_addr", got_ra, e.row);
    check("oe_len", k, e.oe_len);
    check("oe_in_blank", oe_seen, 0);
    check("row_addr_stable", ra_bad, 0);
    $display("slot row=%0d plane=%0d frame_start=%0d oe_cycles=%0d", s_row, s_plane, s_fs, k);
    if (drop_en) begin
      m_row   = 0;
      m_plane = 0;
    end else begin
      model_next();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    enable   = 1'b0;
    complete = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_load", int'(load), 0);
    check("reset_latch", int'(latch), 0);
    check("reset_oe", int'(oe), 0);
    check("reset_frame_start", int'(frame_start), 0);
    check("reset_row_addr", int'(row_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_no_enable", int'(load), 0);
    enable = 1'b1;

    // Full frame plus wrap back to (0,0); a stray complete in one DISPLAY.
    do_slot(1'b0, 1'b0, 1'b0);
    do_slot(1'b0, 1'b0, 1'b0);
    do_slot(1'b0, 1'b0, 1'b1);
    do_slot(1'b0, 1'b0, 1'b0);
    do_slot(1'b0, 1'b0, 1'b0);

    // enable dropped mid-LOAD of (0,1): slot completes, then IDLE.
    do_slot(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("idle_outputs",
            int'({load, latch, oe, frame_start, row_addr, fetch_row, fetch_plane}), 0);
      @(negedge clk);
    end

    // Restart, then reset in the middle of (1,1) DISPLAY.
    enable = 1'b1;
    do_slot(1'b0, 1'b0, 1'b0);
    do_slot(1'b0, 1'b0, 1'b0);
    do_slot(1'b0, 1'b0, 1'b0);
    do_slot(1'b0, 1'b1, 1'b0);
    do_slot(1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
